// File: rtl/s27_bist_tpg.sv
// -----------------------------------------------------------------------------
// s27_bist_tpg -- built-in self-test pattern generator for the s27 core.
//
// Drives the core's four primary inputs (G0..G3) from a 4-bit maximal-length
// LFSR (x^4 + x^3 + 1, Fibonacci, shifting left, period 15). Each session
// starts with START and runs in this order:
//   1. INIT_CYCLES all-zero flush cycles, which bring the core's state flops
//      to a known value.
//   2. NUM_PATTERNS counted patterns.
//   3. DONE, which stays high until the next START.
// HOLD from the downstream compactor stalls the pattern stream while in RUN.
//
// Parameters:
//   SEED         LFSR load value at session start (0 is replaced by 0001)
//   NUM_PATTERNS counted patterns per session, 1 .. 2^CNT_W-1
//   INIT_CYCLES  all-zero flush cycles before the first pattern, 0 .. 15
//   CNT_W        width of the pattern index
//
// Ports:
//   CK         in   clock, rising edge
//   RST        in   asynchronous, active-high reset
//   START      in   session request, sampled only in IDLE and DONE
//   HOLD       in   stall request, acts only in RUN
//   PAT        out  pattern bits, PAT[0]..PAT[3] drive G0..G3
//   PAT_VALID  out  PAT is a counted test pattern this cycle
//   PAT_IDX    out  0-based index of the pattern on PAT
//   DONE       out  session complete, held until the next START
// -----------------------------------------------------------------------------
module s27_bist_tpg #(
  parameter logic [3:0] SEED         = 4'b0001,
  parameter int         NUM_PATTERNS = 15,
  parameter int         INIT_CYCLES  = 3,
  parameter int         CNT_W        = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             HOLD,
  output logic [3:0]       PAT,
  output logic             PAT_VALID,
  output logic [CNT_W-1:0] PAT_IDX,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } state_e;

  // An all-zero LFSR would lock up, so a zero seed falls back to 0001.
  localparam logic [3:0]       SEED_EFF   = (SEED == 4'b0000) ? 4'b0001 : SEED;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_PATTERNS - 1);
  // Only compared while in INIT, which is never entered when INIT_CYCLES == 0.
  localparam logic [3:0]       FLUSH_LAST = 4'(INIT_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       lfsr_q;
  logic [3:0]       lfsr_d;
  logic [3:0]       flush_q;
  logic [CNT_W-1:0] cnt_q;    // index of the pattern currently held in lfsr_q
  logic [3:0]       pat_q;
  logic             valid_q;
  logic [CNT_W-1:0] idx_q;
  logic             done_q;

  // Next LFSR value. x^4 + x^3 + 1 feeds bits 3 and 2 back into bit 0.
  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  // The output registers are loaded from the state the FSM is in at the
  // current edge. So every output lags its state by one cycle:
  //   - The first pattern appears one edge after INIT ends.
  //   - DONE rises one edge after the last pattern.
  // NOTE: all state below uses non-blocking assignments, so every register
  // sees the pre-edge values of the others. This is what lets the FSM
  // compare, shift and count in one edge without ordering hazards.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      lfsr_q  <= 4'b0001;
      flush_q <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // PAT is zero and not valid everywhere except RUN. RUN overrides these.
      pat_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= (state_q == ST_DONE);
          // A START in DONE restarts immediately, exactly like one in IDLE.
          if (START) begin
            done_q  <= 1'b0;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            flush_q <= '0;
            state_q <= (INIT_CYCLES > 0) ? ST_INIT : ST_RUN;
          end
        end

        ST_INIT: begin
          // Stay for exactly INIT_CYCLES cycles. START and HOLD are ignored.
          if (flush_q == FLUSH_LAST) begin
            state_q <= ST_RUN;
          end else begin
            flush_q <= flush_q + 4'd1;
          end
        end

        ST_RUN: begin
          if (HOLD) begin
            // Stall: the displayed pattern and its index stay frozen, and
            // PAT_VALID drops so the compactor does not sample the repeat.
            pat_q <= pat_q;
          end else begin
            pat_q   <= lfsr_q;
            valid_q <= 1'b1;
            idx_q   <= cnt_q;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PAT       = pat_q;
  assign PAT_VALID = valid_q;
  assign PAT_IDX   = idx_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_s27_bist_tpg.sv
// -----------------------------------------------------------------------------
// tb_s27_bist_tpg -- self-checking bench for s27_bist_tpg.
//
// Four instances with different parameter sets share the clock and reset. Each
// instance has its own START/HOLD. The reference model works in session terms:
//   - a count of flush cycles left;
//   - a count of patterns emitted;
//   - the published LFSR sequence table.
// From these it predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_s27_bist_tpg;

  logic       ck = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [3:0] hold;
  logic [3:0] pat [4];
  logic [7:0] idx [4];
  logic [3:0] vld;
  logic [3:0] done;

  int total = 0;
  int bad   = 0;

  // Per-instance configuration, as seen from outside. Instance 2 uses SEED=0,
  // so its effective seed is 0001.
  int         cfg_num  [4] = '{15, 17, 15, 15};
  int         cfg_init [4] = '{3, 0, 3, 3};
  logic [3:0] cfg_seed [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b1101};

  // Full period of x^4 + x^3 + 1, starting from 0001.
  logic [3:0] seq_tbl [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 ck = ~ck;

  s27_bist_tpg u_def (
    .CK(ck), .RST(rst), .START(start[0]), .HOLD(hold[0]),
    .PAT(pat[0]), .PAT_VALID(vld[0]), .PAT_IDX(idx[0]), .DONE(done[0])
  );

  s27_bist_tpg #(.NUM_PATTERNS(17), .INIT_CYCLES(0)) u_wrap (
    .CK(ck), .RST(rst), .START(start[1]), .HOLD(hold[1]),
    .PAT(pat[1]), .PAT_VALID(vld[1]), .PAT_IDX(idx[1]), .DONE(done[1])
  );

  s27_bist_tpg #(.SEED(4'b0000)) u_seed0 (
    .CK(ck), .RST(rst), .START(start[2]), .HOLD(hold[2]),
    .PAT(pat[2]), .PAT_VALID(vld[2]), .PAT_IDX(idx[2]), .DONE(done[2])
  );

  s27_bist_tpg #(.SEED(4'b1101)) u_seedd (
    .CK(ck), .RST(rst), .START(start[3]), .HOLD(hold[3]),
    .PAT(pat[3]), .PAT_VALID(vld[3]), .PAT_IDX(idx[3]), .DONE(done[3])
  );

  // Runs one session on instance k and checks every cycle against the model.
  //   hold_pct  : random HOLD probability, in percent
  //   hold_idx  : index at which a deterministic stall of hold_len cycles
  //               starts (-1 for none)
  //   noise     : drive random START/HOLD during flush and run
  // Returns the edge (counted from the START edge) at which PAT_VALID was
  // first seen high and the edge at which DONE was first seen high.
  task automatic run_session(input int k, input int hold_pct, input int hold_idx,
                             input int hold_len, input bit noise, input string name,
                             output int first_v, output int done_e);
    int pos, n, flush_rem, stalls, edges;
    bit fin, h;
    logic [3:0] ep;
    logic [7:0] ei;
    logic       ev, ed;

    pos = 0;
    for (int i = 0; i < 15; i++) if (seq_tbl[i] == cfg_seed[k]) pos = i;

    // START edge. A simultaneous HOLD must lose to START.
    start[k] = 1'b1;
    hold[k]  = 1'($urandom % 2);
    @(posedge ck); #1;
    start[k] = 1'b0;
    hold[k]  = 1'b0;
    ep = '0; ev = 1'b0; ei = '0; ed = 1'b0;
    total++;
    if ({pat[k], vld[k], idx[k], done[k]} !== {ep, ev, ei, ed}) begin
      bad++;
      $display("FAIL %s start: pat=%b vld=%b idx=%0d done=%b want pat=%b vld=%b idx=%0d done=%b",
               name, pat[k], vld[k], idx[k], done[k], ep, ev, ei, ed);
    end

    flush_rem = cfg_init[k];
    n = 0; stalls = 0; edges = 0; fin = 1'b0;
    first_v = -1; done_e = -1;
    while (!fin && edges < 2000) begin
      h = 1'b0;
      if (hold_pct > 0 && $urandom_range(99) < hold_pct) h = 1'b1;
      if (hold_idx >= 0 && n > hold_idx && ei == 8'(hold_idx) && stalls < hold_len) begin
        h = 1'b1;
        stalls++;
      end
      if (noise && flush_rem > 0) h = 1'($urandom % 2);
      hold[k]  = h;
      // START must stay low on the edge that enters DONE's first cycle,
      // otherwise the session would legitimately restart.
      start[k] = (noise && n < cfg_num[k]) ? 1'($urandom % 2) : 1'b0;
      @(posedge ck);
      edges++;
      if (flush_rem > 0) begin
        flush_rem--;
      end else if (n == cfg_num[k]) begin
        ed = 1'b1; ep = '0; ev = 1'b0; fin = 1'b1;
      end else if (h) begin
        ev = 1'b0;
      end else begin
        ep = seq_tbl[(pos + n) % 15];
        ei = 8'(n);
        ev = 1'b1;
        n++;
      end
      #1;
      start[k] = 1'b0;
      hold[k]  = 1'b0;
      if (first_v < 0 && vld[k] === 1'b1) first_v = edges;
      if (done_e < 0 && done[k] === 1'b1) done_e = edges;
      total++;
      if ({pat[k], vld[k], idx[k], done[k]} !== {ep, ev, ei, ed}) begin
        bad++;
        $display("FAIL %s edge %0d: pat=%b vld=%b idx=%0d done=%b want pat=%b vld=%b idx=%0d done=%b",
                 name, edges, pat[k], vld[k], idx[k], done[k], ep, ev, ei, ed);
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL %s timeout: edges=%0d want session end", name, edges);
    end

    // DONE and the last index must persist while START stays low.
    @(posedge ck); #1;
    total++;
    if ({pat[k], vld[k], idx[k], done[k]} !== {4'b0, 1'b0, 8'(cfg_num[k] - 1), 1'b1}) begin
      bad++;
      $display("FAIL %s done_hold: pat=%b vld=%b idx=%0d done=%b want pat=0000 vld=0 idx=%0d done=1",
               name, pat[k], vld[k], idx[k], done[k], cfg_num[k] - 1);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({pat[k], vld[k], idx[k], done[k]} !== 14'b0) begin
        bad++;
        $display("FAIL %s inst%0d: pat=%b vld=%b idx=%0d done=%b want all zero",
                 name, k, pat[k], vld[k], idx[k], done[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset_assert");
    repeat (2) @(posedge ck);
    #2 rst = 1'b0;
    repeat (3) @(posedge ck);
    #1 check_all_zero("reset_idle");
  endtask

  task automatic test_default();
    int fv, de;
    run_session(0, 0, -1, 0, 1'b0, "default", fv, de);
    total++;
    if (fv !== 4 || de !== 19) begin
      bad++;
      $display("FAIL default_latency: first_valid=%0d done=%0d want 4 and 19", fv, de);
    end
  endtask

  task automatic test_hold_stall();
    int fv, de;
    run_session(0, 0, 3, 2, 1'b0, "hold_stall", fv, de);
    total++;
    if (fv !== 4 || de !== 21) begin
      bad++;
      $display("FAIL hold_latency: first_valid=%0d done=%0d want 4 and 21", fv, de);
    end
  endtask

  task automatic test_wrap();
    int fv, de;
    run_session(1, 0, -1, 0, 1'b0, "wrap", fv, de);
    total++;
    if (fv !== 1 || de !== 18) begin
      bad++;
      $display("FAIL wrap_latency: first_valid=%0d done=%0d want 1 and 18", fv, de);
    end
    run_session(1, 30, -1, 0, 1'b1, "wrap_rand", fv, de);
  endtask

  task automatic test_start_ignored();
    int fv, de;
    run_session(0, 25, -1, 0, 1'b1, "start_noise", fv, de);
  endtask

  task automatic test_restart();
    int fv, de;
    // Instance 0 is sitting in DONE here, so this START restarts from DONE.
    run_session(0, 0, -1, 0, 1'b0, "restart", fv, de);
    total++;
    if (fv !== 4 || de !== 19) begin
      bad++;
      $display("FAIL restart_latency: first_valid=%0d done=%0d want 4 and 19", fv, de);
    end
  endtask

  task automatic test_seed();
    int fv, de;
    run_session(2, 20, -1, 0, 1'b0, "seed_zero", fv, de);
    run_session(3, 20, -1, 0, 1'b1, "seed_1101", fv, de);
  endtask

  task automatic test_reset_mid();
    int fv, de;
    start[0] = 1'b1;
    @(posedge ck); #1 start[0] = 1'b0;
    repeat (7) @(posedge ck);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid");
    @(negedge ck) rst = 1'b0;
    repeat (4) @(posedge ck);
    #1 check_all_zero("reset_no_resume");
    run_session(0, 15, -1, 0, 1'b0, "after_reset", fv, de);
  endtask

  initial begin
    start = '0;
    hold  = '0;
    test_reset();
    test_default();
    test_hold_stall();
    test_wrap();
    test_start_ignored();
    test_restart();
    test_seed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
